// File: rtl/fpu_pkg.sv
// Shared FPU definitions for the float<->int converters (ftoi and its inverse itof).
// Provides binary32 field widths, the exponent bias, integer saturation limits,
// the packed binary32 view and the ftoi stage-1 operand class.
package fpu_pkg;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;

  localparam logic [31:0] INT_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp32_t;

  // Operand class decided at decode. FC_ZERO must stay the all-zero encoding:
  // the reset value of the pipeline then produces a clean 0 result.
  typedef enum logic [2:0] {
    FC_ZERO,   // exp == 0 (zero / denormal)
    FC_SMALL,  // |x| < 0.5
    FC_HALF,   // 0.5 <= |x| < 1, rounds to magnitude 1
    FC_NORM,   // 1 <= |x| < 2^31, goes through the shifter
    FC_MIN,    // exactly -2^31, representable
    FC_SAT     // out of range, Inf or NaN
  } ftoi_class_t;
endpackage

// File: rtl/ftoi_shift.sv
// Combinational barrel shifter for ftoi stage 2.
// Ports:
//   sig_i  24-bit significand {1, man}
//   sh_i   signed shift (exp - 150): negative shifts right, positive shifts left
//   mag_o  31-bit truncated magnitude
//   rnd_o  first discarded bit on a right shift (0 for left shifts)
module ftoi_shift (
  input  logic        [23:0] sig_i,
  input  logic signed [5:0]  sh_i,
  output logic        [30:0] mag_o,
  output logic               rnd_o
);
  logic [4:0] rsh;
  assign rsh = 5'(-sh_i);

  always_comb begin
    if (sh_i[5]) begin
      mag_o = 31'(sig_i >> rsh);
      rnd_o = sig_i[rsh - 5'd1];
    end else begin
      // Left shift is at most 7, so 24+7 bits always fit and nothing is lost.
      mag_o = {7'b0, sig_i} << sh_i[2:0];
      rnd_o = 1'b0;
    end
  end
endmodule

// File: rtl/ftoi.sv
// Pipelined binary32 -> signed 32-bit integer converter, round half away from zero,
// saturating on out-of-range, Inf and NaN. Three register stages, global stall.
// Ports:
//   clk, reset         clock, async active-high reset
//   op1, valid_in      operand and its valid tag
//   stall              freeze every stage; inputs at a stalled edge are dropped
//   result, overflow   converted integer and saturation flag
//   valid_out          result/overflow carry a completed conversion
module ftoi
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] op1,
  input  logic        valid_in,
  input  logic        stall,
  output logic [31:0] result,
  output logic        valid_out,
  output logic        overflow
);
  fp32_t fp;
  assign fp = op1;

  logic [3:1] vld_pipe_q;

  // ---------------- stage 1: decode ----------------
  ftoi_class_t        cls1_d, cls1_q;
  logic               s1_d, s1_q;
  logic signed [5:0]  sh1_d, sh1_q;
  logic        [23:0] sig1_d, sig1_q;
  logic               is_nan;

  assign is_nan = (fp.exp == '1) && (fp.man != '0);

  always_comb begin
    s1_d   = fp.sign;
    sig1_d = {1'b1, fp.man};
    // Only meaningful for FC_NORM, where it lies in -23..7 and fits 6 bits.
    sh1_d  = 6'(fp.exp - 8'(BIAS + MAN_W));
    if (fp.exp == '0)                                       cls1_d = FC_ZERO;
    else if (fp.exp < 8'(BIAS - 1))                         cls1_d = FC_SMALL;
    else if (fp.exp == 8'(BIAS - 1))                        cls1_d = FC_HALF;
    else if (fp.exp < 8'(BIAS + 31))                        cls1_d = FC_NORM;
    else if (fp.exp == 8'(BIAS + 31) && fp.sign && fp.man == '0) cls1_d = FC_MIN;
    else begin
      cls1_d = FC_SAT;
      // NaN saturates positive whatever its sign bit says.
      if (is_nan) s1_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cls1_q <= FC_ZERO;
      s1_q   <= 1'b0;
      sh1_q  <= '0;
      sig1_q <= '0;
    end else if (!stall) begin
      cls1_q <= cls1_d;
      s1_q   <= s1_d;
      sh1_q  <= sh1_d;
      sig1_q <= sig1_d;
    end
  end

  // ---------------- stage 2: shift ----------------
  logic [30:0]  shf_mag, mag2_d, mag2_q;
  logic         shf_rnd, rnd2_d, rnd2_q;
  ftoi_class_t  cls2_q;
  logic         s2_q;

  ftoi_shift u_shift (
    .sig_i (sig1_q),
    .sh_i  (sh1_q),
    .mag_o (shf_mag),
    .rnd_o (shf_rnd)
  );

  always_comb begin
    mag2_d = shf_mag;
    rnd2_d = shf_rnd;
    case (cls1_q)
      FC_ZERO, FC_SMALL: begin mag2_d = '0;    rnd2_d = 1'b0; end
      FC_HALF:           begin mag2_d = 31'd1; rnd2_d = 1'b0; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cls2_q <= FC_ZERO;
      s2_q   <= 1'b0;
      mag2_q <= '0;
      rnd2_q <= 1'b0;
    end else if (!stall) begin
      cls2_q <= cls1_q;
      s2_q   <= s1_q;
      mag2_q <= mag2_d;
      rnd2_q <= rnd2_d;
    end
  end

  // ---------------- stage 3: round, sign, saturate ----------------
  logic [31:0] mag3, res_d, res_q;
  logic        ovf_d, ovf_q;

  always_comb begin
    mag3  = {1'b0, mag2_q} + {31'b0, rnd2_q};
    res_d = s2_q ? -mag3 : mag3;
    ovf_d = 1'b0;
    case (cls2_q)
      FC_MIN: res_d = INT_MIN;
      FC_SAT: begin
        res_d = s2_q ? INT_MIN : INT_MAX;
        ovf_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_q      <= '0;
      ovf_q      <= 1'b0;
      vld_pipe_q <= '0;
    end else if (!stall) begin
      res_q      <= res_d;
      ovf_q      <= ovf_d;
      vld_pipe_q <= {vld_pipe_q[2:1], valid_in};
    end
  end

  assign result    = res_q;
  assign overflow  = ovf_q;
  assign valid_out = vld_pipe_q[3];
endmodule
